pixel_serializer: RTL and testbench
===================================

# pixel_serializer

Consumes groups of NUM_ENGINES RGB pixels, one per engine lane, from the iteration-to-colour lookup stage. Emits them one pixel per cycle as an AXI4-Stream video stream in raster order, generating tuser (start of frame) and tlast (end of line) from internal x/y counters. Sits between the colour lookup output and the video DMA/stream interface. Provides a one-entry group buffer with a valid/ready handshake toward the engines.

## Interface
- RBG_SIZE, 24: bits per pixel and the width of out_tdata.
- NUM_ENGINES, 4: pixels per input group. Lane 0 is the leftmost pixel.
- X_SIZE, 640: pixels per line. Must be a multiple of NUM_ENGINES.
- Y_SIZE, 480: lines per frame.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  in_rbg holds a valid group.
- in_ready  out  1  group accepted on the clk edge where in_valid && in_ready.
- in_rbg  in  [RBG_SIZE-1:0] x NUM_ENGINES (unpacked)  group pixels; lane i is pixel x+i.
- out_tvalid  out  1  AXI-Stream valid.
- out_tready  in  1  AXI-Stream ready.
- out_tdata  out  RBG_SIZE  current pixel.
- out_tuser  out  1  high on pixel (0,0) only.
- out_tlast  out  1  high on pixel x == X_SIZE-1.
- frame_done  out  1  one-cycle pulse on the cycle after the last pixel of a frame transfers.

## Operation
- FSM states:
  - IDLE: buffer empty, out_tvalid = 0, in_ready = 1.
  - SEND: buffer full, out_tvalid = 1.
- IDLE -> SEND on an input handshake. The group is latched and lane = 0.
- In SEND, each out handshake (out_tvalid && out_tready) increments lane and advances the raster counters.
- On an out handshake with lane == NUM_ENGINES-1:
  - If in_valid, latch the new group, set lane = 0 and stay in SEND. There is no bubble.
  - Otherwise go to IDLE.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in SEND when lane == NUM_ENGINES-1 && out_tready.
  - 0 otherwise, and forced to 0 while rst_n = 0.
- out_tdata = buf[lane].
- Raster counters:
  - x is $clog2(X_SIZE) bits and y is $clog2(Y_SIZE) bits. Both advance only on an out handshake.
  - x wraps X_SIZE-1 -> 0 and increments y.
  - At x == X_SIZE-1 && y == Y_SIZE-1 both wrap to 0 and frame_done pulses on the next cycle.
- out_tuser = (x == 0 && y == 0) && out_tvalid.
- out_tlast = (x == X_SIZE-1) && out_tvalid.
- AXI rule: while out_tvalid && !out_tready, out_tdata, out_tuser and out_tlast are held stable. The buffer, lane and counters do not change.
- Input groups are never split across lines, because X_SIZE is a multiple of NUM_ENGINES. A group always starts at an x that is a multiple of NUM_ENGINES.

## Timing
- Reset (rst_n = 0 at an edge):
  - State goes to IDLE; x, y and lane go to 0; the buffer is cleared to 0.
  - out_tvalid, out_tuser, out_tlast, out_tdata and frame_done are all 0.
  - Reset mid-frame discards the buffered group. The next accepted group is pixel (0,0).
- Latency: a group accepted at edge N presents lane 0 on out_tdata and out_tvalid in the cycle after edge N.
- Throughput: one pixel per cycle when out_tready is held at 1 and in_valid stays at 1. A new group is accepted every NUM_ENGINES cycles.
- A simultaneous last-lane out handshake and input handshake (back-to-back) is handled as one event: lane N-1 is output, then lane 0 of the new group follows in the next cycle.
- If in_valid is deasserted mid-group, there is no effect; only the handshake edge matters.
- frame_done is registered: it is high for exactly one cycle, in the cycle after the final handshake.

## Structure
- Package mandel_pkg holds:
  - the shared constants RBG_SIZE, NUM_ENGINES, X_SIZE and Y_SIZE, which are also used by the colour lookup stage and the engines;
  - typedef rgb_t (logic [RBG_SIZE-1:0]);
  - enum ser_state_t {IDLE, SEND}.
- One sub-module, raster_counter. It owns the x/y counters and takes an advance strobe. Outputs:
  - sof (start of frame, x == 0 && y == 0);
  - eol (end of line, x == X_SIZE-1);
  - eof (end of frame, last pixel).
- pixel_serializer holds the FSM, the group buffer, the lane index and the frame_done register.

## Test plan
All scenarios use X_SIZE = 8, Y_SIZE = 2, NUM_ENGINES = 4.

- Reset, then in_valid = 0 -> in_ready = 1, out_tvalid = 0, frame_done = 0 for 10 cycles.
- One group {0x000001, 0x000002, 0x000003, 0x000004}, out_tready = 1 -> tdata 1, 2, 3, 4 on 4 consecutive cycles starting the cycle after acceptance. tuser is high only on 0x000001.
- Four groups back-to-back, in_valid and out_tready held at 1 -> 16 pixels with no gaps:
  - tlast on pixels 7 and 15;
  - tuser on pixel 0;
  - frame_done pulses once, the cycle after pixel 15;
  - in_ready is high on the last-lane cycles.
- out_tready toggled 1, 0, 0, 1, ... in a pseudo-random pattern -> tdata, tuser and tlast are stable across stalls, and the pixel order matches the input exactly.
- Frame wrap: 5 groups -> the 17th pixel (group 5, lane 0) has tuser = 1 and x = 0.
- rst_n pulsed low during lane 2 of group 2 -> after reset out_tvalid = 0. The next group is emitted with tuser = 1 on its lane 0.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: constants and types shared by the escape-time engines, the
// colour lookup stage and the pixel serializer.
//   RBG_SIZE    : bits per RGB pixel
//   NUM_ENGINES : pixels produced per group (one per engine lane)
//   X_SIZE      : pixels per line (multiple of NUM_ENGINES)
//   Y_SIZE      : lines per frame
package mandel_pkg;
   localparam int RBG_SIZE    = 24;
   localparam int NUM_ENGINES = 4;
   localparam int X_SIZE      = 640;
   localparam int Y_SIZE      = 480;

   typedef logic [RBG_SIZE-1:0] rgb_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;
endpackage

// File: rtl/pixel_serializer_if.sv
// pixel_serializer_if: group input handshake plus the AXI4-Stream video output.
//   in_valid/in_ready/in_rbg : one group of NUM_ENGINES pixels, lane 0 leftmost
//   out_t*                   : one pixel per transfer, tuser = SOF, tlast = EOL
// Modports:
//   master : the serializer (accepts groups, drives the stream)
//   slave  : the surroundings (engines supply groups, DMA sinks the stream)
interface pixel_serializer_if #(
   parameter int RBG_SIZE    = mandel_pkg::RBG_SIZE,
   parameter int NUM_ENGINES = mandel_pkg::NUM_ENGINES
);
   logic                in_valid;
   logic                in_ready;
   logic [RBG_SIZE-1:0] in_rbg [NUM_ENGINES];
   logic                out_tvalid;
   logic                out_tready;
   logic [RBG_SIZE-1:0] out_tdata;
   logic                out_tuser;
   logic                out_tlast;

   modport master (
      input  in_valid, in_rbg, out_tready,
      output in_ready, out_tvalid, out_tdata, out_tuser, out_tlast
   );

   modport slave (
      output in_valid, in_rbg, out_tready,
      input  in_ready, out_tvalid, out_tdata, out_tuser, out_tlast
   );
endinterface

// File: rtl/raster_counter.sv
// raster_counter: x/y position of the pixel currently presented on the stream.
//   clk, rst_n : clock and synchronous active-low reset
//   advance    : a pixel transferred this cycle; step to the next position
//   sof        : x == 0 && y == 0
//   eol        : x == X_SIZE-1
//   eof        : last pixel of the frame (eol on the last line)
module raster_counter #(
   parameter int X_SIZE = mandel_pkg::X_SIZE,
   parameter int Y_SIZE = mandel_pkg::Y_SIZE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic advance,
   output logic sof,
   output logic eol,
   output logic eof
);
   localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign sof = (x_q == '0) && (y_q == '0);
   assign eol = (x_q == XW'(X_SIZE - 1));
   assign eof = eol && (y_q == YW'(Y_SIZE - 1));

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (advance) begin
         if (eol) begin
            x_d = '0;
            y_d = eof ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: turns groups of NUM_ENGINES pixels into a raster-order
// AXI4-Stream video stream, one pixel per cycle.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : group input handshake and stream output (master modport)
//   frame_done : one-cycle pulse the cycle after the last pixel of a frame
// A single group buffer is reloaded on the same edge its last lane leaves, so
// a continuous input keeps the stream gap-free.
module pixel_serializer #(
   parameter int RBG_SIZE    = mandel_pkg::RBG_SIZE,
   parameter int NUM_ENGINES = mandel_pkg::NUM_ENGINES,
   parameter int X_SIZE      = mandel_pkg::X_SIZE,
   parameter int Y_SIZE      = mandel_pkg::Y_SIZE
) (
   input  logic               clk,
   input  logic               rst_n,
   pixel_serializer_if.master bus,
   output logic               frame_done
);
   import mandel_pkg::*;

   localparam int LW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   ser_state_t          state_q, state_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic [RBG_SIZE-1:0] buf_q [NUM_ENGINES];
   logic [RBG_SIZE-1:0] buf_d [NUM_ENGINES];
   logic                frame_done_q, frame_done_d;

   logic out_hs;
   logic last_lane;
   logic load;
   logic sof, eol, eof;

   assign last_lane = (lane_q == LW'(NUM_ENGINES - 1));
   assign out_hs    = (state_q == SEND) && bus.out_tready;

   // Ready is also offered while the final lane is leaving, which is what
   // lets the next group land without a bubble. Held low during reset.
   assign bus.in_ready = rst_n &&
                         ((state_q == IDLE) ||
                          ((state_q == SEND) && last_lane && bus.out_tready));
   assign load = bus.in_valid && bus.in_ready;

   raster_counter #(
      .X_SIZE (X_SIZE),
      .Y_SIZE (Y_SIZE)
   ) u_raster (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (out_hs),
      .sof     (sof),
      .eol     (eol),
      .eof     (eof)
   );

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      frame_done_d = out_hs && eof;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         buf_d[i] = buf_q[i];
      end
      if (load) begin
         // Covers both IDLE acceptance and the back-to-back reload in SEND.
         state_d = SEND;
         lane_d  = '0;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            buf_d[i] = bus.in_rbg[i];
         end
      end else if (out_hs) begin
         if (last_lane) begin
            state_d = IDLE;
         end else begin
            lane_d = lane_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lane_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         frame_done_q <= frame_done_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_buf
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               buf_q[gi] <= '0;
            end else begin
               buf_q[gi] <= buf_d[gi];
            end
         end
      end
   endgenerate

   assign bus.out_tvalid = (state_q == SEND);
   assign bus.out_tdata  = buf_q[lane_q];
   assign bus.out_tuser  = sof && bus.out_tvalid;
   assign bus.out_tlast  = eol && bus.out_tvalid;
   assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_pixel_serializer.sv
module tb_pixel_serializer;
   localparam int NE = 4;
   localparam int XS = 8;
   localparam int YS = 2;
   localparam int FR = XS * YS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_done;

   always #5 clk = ~clk;

   pixel_serializer_if #(.RBG_SIZE(24), .NUM_ENGINES(NE)) bus ();

   pixel_serializer #(
      .RBG_SIZE    (24),
      .NUM_ENGINES (NE),
      .X_SIZE      (XS),
      .Y_SIZE      (YS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .frame_done (frame_done)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: pixels waiting to enter, pixels accepted but not yet out.
   logic [23:0] src_q[$];
   logic [23:0] exp_q[$];
   int          pix_cnt;
   bit          fd_pending;
   int          fd_count;
   bit          prev_stall;
   logic [23:0] prev_data;
   logic        prev_user, prev_last;

   // Statistics from the latest run_stream call.
   int          last_cycles;
   int          first_xfer_cyc;
   int          ready_on_last;
   logic        user0, user16;

   task automatic clear_model();
      exp_q.delete();
      pix_cnt    = 0;
      fd_pending = 0;
      fd_count   = 0;
      prev_stall = 0;
   endtask

   task automatic push_group_random();
      for (int i = 0; i < NE; i++) src_q.push_back(24'($urandom));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.out_tvalid !== 1'b0 || bus.out_tuser !== 1'b0 || bus.out_tlast !== 1'b0 ||
          bus.out_tdata !== 24'h0 || frame_done !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got tvalid=%b tuser=%b tlast=%b tdata=%h fd=%b in_ready=%b, required all 0",
                  bus.out_tvalid, bus.out_tuser, bus.out_tlast, bus.out_tdata, frame_done, bus.in_ready);
      end
      rst_n = 1'b1;
      clear_model();
   endtask

   // mode 0: in_valid whenever a group is available, out_tready = 1.
   // mode 1: random input gaps and random out_tready.
   // stop_after > 0 ends the run after that many output transfers.
   task automatic run_stream(input int mode, input int stop_after);
      int  cyc = 0;
      int  xfers = 0;
      bit  ready_exp, xfer, in_hs;
      last_cycles    = 0;
      first_xfer_cyc = -1;
      ready_on_last  = 0;
      while (!((src_q.size() == 0 && exp_q.size() == 0) ||
               (stop_after > 0 && xfers >= stop_after))) begin
         if (cyc > 2000) begin
            errors++;
            checks++;
            $display("FAIL timeout: got %0d pixels pending after %0d cycles, required 0", exp_q.size(), cyc);
            break;
         end
         @(negedge clk);
         bus.out_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.in_valid   = (src_q.size() >= NE) && (mode == 0 || $urandom_range(0, 3) != 0);
         for (int i = 0; i < NE; i++)
            bus.in_rbg[i] = bus.in_valid ? src_q[i] : 24'($urandom);
         #1;
         checks++;
         if (frame_done !== fd_pending) begin
            errors++;
            $display("FAIL frame_done: got %b required %b at pixel %0d", frame_done, fd_pending, pix_cnt);
         end
         if (frame_done === 1'b1) fd_count++;
         checks++;
         if (bus.out_tvalid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL tvalid: got %b required %b", bus.out_tvalid, exp_q.size() != 0);
         end
         ready_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_tready);
         checks++;
         if (bus.in_ready !== ready_exp) begin
            errors++;
            $display("FAIL in_ready: got %b required %b", bus.in_ready, ready_exp);
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_tdata !== prev_data || bus.out_tuser !== prev_user || bus.out_tlast !== prev_last) begin
               errors++;
               $display("FAIL stall_hold: got %h/%b/%b required %h/%b/%b",
                        bus.out_tdata, bus.out_tuser, bus.out_tlast, prev_data, prev_user, prev_last);
            end
         end
         xfer  = (exp_q.size() != 0) && bus.out_tready;
         in_hs = bus.in_valid && ready_exp;
         fd_pending = xfer && ((pix_cnt % FR) == FR - 1);
         prev_stall = (exp_q.size() != 0) && !bus.out_tready;
         prev_data  = bus.out_tdata;
         prev_user  = bus.out_tuser;
         prev_last  = bus.out_tlast;
         if (xfer) begin
            checks++;
            if (bus.out_tdata !== exp_q[0] || bus.out_tuser !== ((pix_cnt % FR) == 0) ||
                bus.out_tlast !== ((pix_cnt % XS) == XS - 1)) begin
               errors++;
               $display("FAIL pixel%0d: got %h/%b/%b required %h/%b/%b", pix_cnt,
                        bus.out_tdata, bus.out_tuser, bus.out_tlast,
                        exp_q[0], (pix_cnt % FR) == 0, (pix_cnt % XS) == XS - 1);
            end
            $display("xfer pixel=%0d data=%h tuser=%b tlast=%b", pix_cnt, bus.out_tdata, bus.out_tuser, bus.out_tlast);
            if (pix_cnt == 0)  user0  = bus.out_tuser;
            if (pix_cnt == 16) user16 = bus.out_tuser;
            if ((pix_cnt % NE) == NE - 1 && bus.in_ready === 1'b1) ready_on_last++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            void'(exp_q.pop_front());
            pix_cnt++;
            xfers++;
         end
         if (in_hs) begin
            for (int i = 0; i < NE; i++) exp_q.push_back(src_q.pop_front());
         end
         cyc++;
      end
      last_cycles = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (frame_done !== fd_pending) begin
         errors++;
         $display("FAIL frame_done_tail: got %b required %b", frame_done, fd_pending);
      end
      if (frame_done === 1'b1) fd_count++;
      fd_pending = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_tvalid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle: got in_ready=%b tvalid=%b fd=%b required 1/0/0",
                     bus.in_ready, bus.out_tvalid, frame_done);
         end
      end
   endtask

   task automatic test_single_group();
      do_reset();
      src_q.delete();
      for (int i = 1; i <= NE; i++) src_q.push_back(24'(i));
      run_stream(0, 0);
      checks++;
      if (first_xfer_cyc !== 1) begin
         errors++;
         $display("FAIL latency: got first pixel in cycle %0d required 1", first_xfer_cyc);
      end
      checks++;
      if (last_cycles !== NE + 1) begin
         errors++;
         $display("FAIL single_cycles: got %0d required %0d", last_cycles, NE + 1);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      src_q.delete();
      repeat (4) push_group_random();
      run_stream(0, 0);
      checks++;
      if (last_cycles !== 17) begin
         errors++;
         $display("FAIL b2b_gapless: got %0d cycles required 17", last_cycles);
      end
      checks++;
      if (fd_count !== 1) begin
         errors++;
         $display("FAIL b2b_frame_done_count: got %0d required 1", fd_count);
      end
      checks++;
      if (ready_on_last !== 4) begin
         errors++;
         $display("FAIL b2b_ready_last: got %0d required 4", ready_on_last);
      end
   endtask

   task automatic test_stall();
      do_reset();
      src_q.delete();
      repeat (6) push_group_random();
      run_stream(1, 0);
   endtask

   task automatic test_frame_wrap();
      do_reset();
      src_q.delete();
      repeat (5) push_group_random();
      user16 = 1'b0;
      run_stream(0, 0);
      checks++;
      if (user16 !== 1'b1) begin
         errors++;
         $display("FAIL wrap_tuser: got %b required 1", user16);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_q.delete();
      repeat (3) push_group_random();
      run_stream(0, 6);
      do_reset();
      src_q.delete();
      push_group_random();
      user0 = 1'b0;
      run_stream(0, 0);
      checks++;
      if (user0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_tuser: got %b required 1", user0);
      end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.out_tready = 1'b1;
      for (int i = 0; i < NE; i++) bus.in_rbg[i] = '0;
      test_reset();
      test_single_group();
      test_back_to_back();
      test_stall();
      test_frame_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
